// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter and its skid buffer.
package fifo_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 8;
   localparam int unsigned RD_LAT_MIN     = 1;
   localparam int unsigned RD_LAT_MAX     = 3;

   typedef logic [DATA_WIDTH_DEF-1:0] word_t;

   // Bits needed to count 0..depth words
   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Circular skid buffer: tail-side write, head-side pop, occupancy counter.
module fifo_rd_skid_buf
   import fifo_pkg::*;
#(
   parameter int unsigned Data_Width = DATA_WIDTH_DEF,
   parameter int unsigned SKID_DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 wr,
   input  logic [Data_Width-1:0]                wdata,
   input  logic                                 pop,
   output logic [Data_Width-1:0]                head_data,
   output logic [occ_width(SKID_DEPTH)-1:0]     occupancy
);

   localparam int unsigned PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int unsigned OW = occ_width(SKID_DEPTH);

   typedef enum logic [1:0] {OCC_EMPTY, OCC_PART, OCC_FULL} occ_state_t;

   occ_state_t            occ_state;
   logic [Data_Width-1:0] mem [SKID_DEPTH];
   logic [PW-1:0]         head;
   logic [PW-1:0]         tail;

   // Pointer advance with explicit wrap for non-power-of-2 depths
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(SKID_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      occ_state = OCC_PART;
      if (occupancy == '0)
         occ_state = OCC_EMPTY;
      else if (occupancy == OW'(SKID_DEPTH))
         occ_state = OCC_FULL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head      <= '0;
         tail      <= '0;
         occupancy <= '0;
         for (int i = 0; i < int'(SKID_DEPTH); i++)
            mem[i] <= '0;
      end else begin
         if (wr) begin
            mem[tail] <= wdata;
            tail      <= ptr_inc(tail);
         end
         if (pop)
            head <= ptr_inc(head);
         case ({wr, pop})
            2'b10:   occupancy <= occupancy + OW'(1);
            2'b01:   occupancy <= occupancy - OW'(1);
            default: occupancy <= occupancy;
         endcase
      end
   end

   assign head_data = mem[head];

   // Credit-based issue must never overrun or underrun the buffer
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(wr && !pop && occ_state == OCC_FULL));
   a_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(pop && occ_state == OCC_EMPTY));

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO pull interface to valid/ready stream with credit-based prefetch.
// FIFO_RD_STATS_EN adds word_cnt / starve_cnt counters.
module fifo_rd_stream
   import fifo_pkg::*;
#(
   parameter int unsigned Data_Width = DATA_WIDTH_DEF,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned SKID_DEPTH = 4
) (
   input  logic                             rclk,
   input  logic                             r_rst,
   input  logic                             empty,
   output logic                             r_en,
   input  logic [Data_Width-1:0]            rdata,
   output logic                             m_valid,
   input  logic                             m_ready,
   output logic [Data_Width-1:0]            m_data,
`ifdef FIFO_RD_STATS_EN
   output logic [occ_width(SKID_DEPTH)-1:0] occupancy,
   output logic [31:0]                      word_cnt,
   output logic [31:0]                      starve_cnt
`else
   output logic [occ_width(SKID_DEPTH)-1:0] occupancy
`endif
);

   localparam int unsigned CW = $clog2(2 * SKID_DEPTH + 1);

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
      $fatal(1, "fifo_rd_stream: RD_LAT out of range 1..3");
   end
   if (SKID_DEPTH < RD_LAT + 1) begin : g_bad_depth
      $fatal(1, "fifo_rd_stream: SKID_DEPTH must be at least RD_LAT+1");
   end

   logic [RD_LAT-1:0] inflight;
   logic [CW-1:0]     inflight_cnt;
   logic [CW-1:0]     credit_used;
   logic              pop;
   logic              wr;

   assign pop = m_valid && m_ready;
   assign wr  = inflight[RD_LAT-1];

   always_comb begin
      inflight_cnt = '0;
      for (int i = 0; i < int'(RD_LAT); i++)
         inflight_cnt = inflight_cnt + CW'(inflight[i]);
   end

   // Issue only when every outstanding read is guaranteed a buffer slot
   assign credit_used = CW'(occupancy) + inflight_cnt - CW'(pop);
   assign r_en        = !r_rst && !empty && (credit_used < CW'(SKID_DEPTH));

   always_ff @(posedge rclk) begin
      if (r_rst) begin
         inflight <= '0;
      end else begin
         inflight[0] <= r_en;
         for (int i = 1; i < int'(RD_LAT); i++)
            inflight[i] <= inflight[i-1];
      end
   end

   fifo_rd_skid_buf #(
      .Data_Width (Data_Width),
      .SKID_DEPTH (SKID_DEPTH)
   ) u_skid (
      .clk       (rclk),
      .rst       (r_rst),
      .wr        (wr),
      .wdata     (rdata),
      .pop       (pop),
      .head_data (m_data),
      .occupancy (occupancy)
   );

   assign m_valid = (occupancy != '0);

`ifdef FIFO_RD_STATS_EN
   // Delivered-word count wraps; starvation count saturates
   always_ff @(posedge rclk) begin
      if (r_rst) begin
         word_cnt   <= '0;
         starve_cnt <= '0;
      end else begin
         if (pop)
            word_cnt <= word_cnt + 32'd1;
         if (m_ready && !m_valid && empty && (starve_cnt != '1))
            starve_cnt <= starve_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer of the async FIFO top, in the read clock domain.
- Converts the FIFO's pull interface (empty / r_en / data_out with fixed read latency) into a valid/ready stream for downstream logic.
- Prefetches words into a small skid buffer, keeping full throughput (1 word/cycle) under back-pressure while never reading an empty FIFO.

Parameters:
- Data_Width, 8, FIFO word width and stream data width.
- RD_LAT, 1, rclk cycles from r_en sampled high to the matching word on rdata; legal 1..3.
- SKID_DEPTH, 4, skid buffer entries; must be >= RD_LAT+1. Elaboration fatal error otherwise.

Ports:
- rclk  in  1  read-domain clock.
- r_rst  in  1  reset, synchronous, active-high.
- empty  in  1  FIFO empty flag (rclk domain).
- r_en  out  1  FIFO read enable.
- rdata  in  Data_Width  FIFO data_out; valid exactly RD_LAT cycles after an accepted r_en.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream accept.
- m_data  out  Data_Width  stream word.
- occupancy  out  $clog2(SKID_DEPTH+1)  words held in the skid buffer (excludes in-flight reads).

Behaviour:
- Interface: one clock (rclk); reset (r_rst) is synchronous and active-high.
- Reset values: r_en=0, m_valid=0, m_data=0, occupancy=0. In-flight shift register cleared, head/tail pointers cleared.
- Issue rule (combinational):
  - r_en = !r_rst && !empty && (occupancy + inflight_cnt - pop) < SKID_DEPTH.
  - pop = m_valid && m_ready.
  - inflight_cnt = number of 1s in the RD_LAT-deep valid shift register.
- Read return:
  - The r_en pipeline shifts a 1 per issued read.
  - When the bit exits stage RD_LAT, rdata is written at tail and tail increments mod SKID_DEPTH.
- Buffer: circular, head/tail of $clog2(SKID_DEPTH) bits plus occupancy counter. Wrap-around from SKID_DEPTH-1 to 0 for non-power-of-2 depths.
- Output: m_data = buf[head] (registered storage, combinational select). m_valid = (occupancy != 0). Pop increments head.
- Occupancy state machine, derived from occupancy, no extra state register:
  - EMPTY (0) -> PART on write.
  - PART -> EMPTY on pop without write.
  - PART -> FULL on write without pop reaching SKID_DEPTH.
  - FULL -> PART on pop.
- Simultaneous write and pop: occupancy unchanged; both pointers advance. Legal in every state, including FULL. The credit rule guarantees no write arrives at FULL without a same-cycle pop.
- Overflow impossible by construction. An assertion fires if a write occurs with occupancy==SKID_DEPTH and no pop.
- empty high: r_en=0; in-flight reads still land.
- m_valid stays high and m_data stays stable until accepted (AXI-style; no retraction).
- Latency:
  - Empty buffer, FIFO non-empty: first m_valid RD_LAT+1 cycles after empty falls.
  - Continuous m_ready=1: one word per cycle in steady state.
- Reset mid-operation: all state cleared the same edge. Words arriving on rdata after reset from pre-reset reads are discarded because the in-flight pipeline is cleared. The FIFO's own reset covers its pointers.
- Width rule: occupancy + inflight_cnt is computed at $clog2(2*SKID_DEPTH+1) bits, so there is no overflow.

Optional Feature:
- Macro: FIFO_RD_STATS_EN.
- When defined, adds outputs:
  - word_cnt (32 bits): increments on every pop, wraps at 2^32.
  - starve_cnt (32 bits): increments on cycles with m_ready=1, m_valid=0, empty=1; saturates at 2^32-1.
  - Both reset to 0 on r_rst.
- When undefined, neither port nor logic exists. Core behaviour is identical in both builds.

Decomposition:
- Shared package fifo_pkg: Data_Width default, RD_LAT bounds, a function for occupancy-width computation, and a typedef for the stream word.
- One natural sub-module, fifo_rd_skid_buf: circular storage, head/tail/occupancy, write/pop ports.
- Issue logic, latency pipeline and stats counters stay in fifo_rd_stream.

Test Plan:
- Reset then empty=1 for 10 cycles -> r_en, m_valid, occupancy all 0 throughout.
- empty=0 with 6 words 0xA0..0xA5 queued, m_ready=1, RD_LAT=1 -> first m_valid 2 cycles after empty falls; 0xA0..0xA5 delivered on consecutive cycles; r_en never high after empty rises.
- m_ready=0, FIFO holding 10 words, SKID_DEPTH=4 -> exactly 4 r_en pulses total, occupancy settles at 4, m_data holds the first word stable.
- Release m_ready=1 with the buffer FULL -> pop and write in the same cycle; occupancy stays 4; words delivered in order with no gap or duplicate.
- Assert r_rst for 1 cycle while 2 reads are in flight (RD_LAT=2) -> occupancy=0 and m_valid=0 next cycle; the 2 late rdata words are never presented.
- With FIFO_RD_STATS_EN, deliver 7 words, then hold m_ready=1 with empty=1 for 5 cycles -> word_cnt=7, starve_cnt=5.
